// File: rtl/bmu_pkg.sv
// bmu_pkg: shared definitions for the parametrised branch metric unit.
//   mw_f(n, q)      : metric width for n code bits of q-bit soft samples
//   soft_max_f(q)   : strongest soft '1' sample value for q-bit samples
//   DEF_*           : defaults of the legacy (3,2,2) configuration, including
//                     its expected-codeword table, used to load the table.
package bmu_pkg;

  // Width able to hold the worst-case metric n * (2^q - 1).
  function automatic int mw_f(input int n, input int q);
    return $clog2(n * ((1 << q) - 1) + 1);
  endfunction

  // Largest unsigned soft sample, i.e. a maximally confident '1'.
  function automatic int soft_max_f(input int q);
    return (1 << q) - 1;
  endfunction

  localparam int DEF_N        = 3;
  localparam int DEF_Q        = 3;
  localparam int DEF_NB       = 8;
  localparam int DEF_SOFT_MAX = soft_max_f(DEF_Q);

  // The (3,2,2) trellis numbers its branches so that branch k carries
  // codeword k; the table is therefore the identity mapping.
  localparam logic [2:0] DEF_CW [DEF_NB] = '{3'd0, 3'd1, 3'd2, 3'd3,
                                            3'd4, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/bmu_param_if.sv
// bmu_param_if: symbol, table-write and metric buses of bmu_param.
//   slave  : the BMU side (receives symbols/writes, drives metrics)
//   master : the producer/consumer side (demapper, ACS, configuration)
// Signals: in_valid/in_ready/rx/erase/soft_mode (symbol in),
//          cw_we/cw_addr/cw_data/cfg_err (table programming),
//          out_valid/out_ready/bm/bm_min_idx (metrics out).
interface bmu_param_if #(
  parameter int N  = 3,
  parameter int Q  = 3,
  parameter int NB = 32
);
  import bmu_pkg::*;

  localparam int AW = $clog2(NB);
  localparam int MW = mw_f(N, Q);

  logic             in_valid;
  logic             in_ready;
  logic [N*Q-1:0]   rx;
  logic [N-1:0]     erase;
  logic             soft_mode;
  logic             cw_we;
  logic [AW-1:0]    cw_addr;
  logic [N-1:0]     cw_data;
  logic             cfg_err;
  logic             out_valid;
  logic             out_ready;
  logic [NB*MW-1:0] bm;
  logic [AW-1:0]    bm_min_idx;

  modport slave (
    input  in_valid, rx, erase, soft_mode, cw_we, cw_addr, cw_data, out_ready,
    output in_ready, cfg_err, out_valid, bm, bm_min_idx
  );

  modport master (
    output in_valid, rx, erase, soft_mode, cw_we, cw_addr, cw_data, out_ready,
    input  in_ready, cfg_err, out_valid, bm, bm_min_idx
  );

endinterface

// File: rtl/bmu_branch_sum.sv
// bmu_branch_sum: metric of one trellis branch.
//   cw  : expected codeword of the branch (bit b selects c1 over c0)
//   c0  : per-bit cost of a transmitted 0, Q bits per code bit
//   c1  : per-bit cost of a transmitted 1, Q bits per code bit
//   sum : sum of the selected costs, MW bits (cannot overflow by construction)
module bmu_branch_sum #(
  parameter int N  = 3,
  parameter int Q  = 3,
  parameter int MW = 5
) (
  input  logic [N-1:0]   cw,
  input  logic [N*Q-1:0] c0,
  input  logic [N*Q-1:0] c1,
  output logic [MW-1:0]  sum
);

  // Select the cost matching each expected bit and accumulate.
  always_comb begin
    sum = '0;
    for (int b = 0; b < N; b++) begin
      if (cw[b]) begin
        sum = sum + MW'(c1[b*Q +: Q]);
      end else begin
        sum = sum + MW'(c0[b*Q +: Q]);
      end
    end
  end

endmodule

// File: rtl/bmu_param.sv
// bmu_param: parametrised branch metric unit for the Viterbi decoder family.
//   clock   : single rising-edge clock
//   reset_n : asynchronous active-low reset, clears pipeline, table and cfg_err
//   bus     : bmu_param_if.slave - symbol in (valid/ready), codeword table
//             write port with sticky cfg_err, metrics out (valid/ready) with
//             bm (NB packed metrics) and bm_min_idx.
// Two stages: S1 holds per-bit cost pairs, S2 holds the output metrics.
module bmu_param
  import bmu_pkg::*;
#(
  parameter int N    = 3,
  parameter int Q    = 3,
  parameter int NB   = 32,
  parameter int NORM = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  bmu_param_if.slave   bus
);

  localparam int AW = $clog2(NB);
  localparam int MW = mw_f(N, Q);
  localparam logic [Q-1:0] SMAX_Q = Q'(soft_max_f(Q));
  localparam logic [Q-1:0] ONE_Q  = Q'(1'b1);

  logic             adv1_s;
  logic             adv2_s;
  logic             idle_s;
  logic             addr_ok_s;
  logic             s1_valid_r;
  logic             out_valid_r;
  logic [N*Q-1:0]   c0_s;
  logic [N*Q-1:0]   c1_s;
  logic [N*Q-1:0]   c0_r;
  logic [N*Q-1:0]   c1_r;
  logic [N-1:0]     cw_r [NB];
  logic [MW-1:0]    sum_s [NB];
  logic [MW-1:0]    min_s;
  logic [AW-1:0]    min_idx_s;
  logic [NB*MW-1:0] bm_s;
  logic [NB*MW-1:0] bm_r;
  logic [AW-1:0]    min_idx_r;
  logic             cfg_err_r;

  // A stage may load when it is empty or its content leaves this cycle.
  assign adv2_s = !out_valid_r || bus.out_ready;
  assign adv1_s = !s1_valid_r || adv2_s;
  assign idle_s = !s1_valid_r && !out_valid_r;

  assign bus.in_ready   = adv1_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.bm         = bm_r;
  assign bus.bm_min_idx = min_idx_r;
  assign bus.cfg_err    = cfg_err_r;

  // Out-of-range table addresses only exist when NB is not a power of two.
  generate
    if (NB == (1 << AW)) begin : g_addr_full
      assign addr_ok_s = 1'b1;
    end else begin : g_addr_part
      assign addr_ok_s = (32'(bus.cw_addr) < 32'(NB));
    end
  endgenerate

  // Per-bit cost pairs of the incoming symbol; hard mode looks at the MSB only.
  always_comb begin
    c0_s = '0;
    c1_s = '0;
    for (int b = 0; b < N; b++) begin
      if (bus.erase[b]) begin
        c0_s[b*Q +: Q] = '0;
        c1_s[b*Q +: Q] = '0;
      end else if (bus.soft_mode) begin
        c0_s[b*Q +: Q] = bus.rx[b*Q +: Q];
        c1_s[b*Q +: Q] = SMAX_Q - bus.rx[b*Q +: Q];
      end else if (bus.rx[b*Q + Q - 1]) begin
        c0_s[b*Q +: Q] = ONE_Q;
        c1_s[b*Q +: Q] = '0;
      end else begin
        c0_s[b*Q +: Q] = '0;
        c1_s[b*Q +: Q] = ONE_Q;
      end
    end
  end

  // Codeword table; writes land only with an empty pipeline, otherwise flagged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NB; k++) begin
        cw_r[k] <= '0;
      end
      cfg_err_r <= 1'b0;
    end else begin
      if (bus.cw_we && addr_ok_s) begin
        if (idle_s) begin
          cw_r[bus.cw_addr] <= bus.cw_data;
        end else begin
          cfg_err_r <= 1'b1;
        end
      end
    end
  end

  // Stage 1: capture cost pairs of an accepted symbol.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      c0_r       <= '0;
      c1_r       <= '0;
    end else begin
      if (adv1_s) begin
        s1_valid_r <= bus.in_valid;
        if (bus.in_valid) begin
          c0_r <= c0_s;
          c1_r <= c1_s;
        end
      end
    end
  end

  // One select-and-add per branch, all reading the current table.
  generate
    for (genvar k = 0; k < NB; k++) begin : g_branch
      bmu_branch_sum #(
        .N  (N),
        .Q  (Q),
        .MW (MW)
      ) u_sum (
        .cw  (cw_r[k]),
        .c0  (c0_r),
        .c1  (c1_r),
        .sum (sum_s[k])
      );
    end
  endgenerate

  // Minimum search; strict less-than keeps the lowest index on ties.
  always_comb begin
    logic lt;
    lt        = 1'b0;
    min_s     = sum_s[0];
    min_idx_s = '0;
    for (int k = 1; k < NB; k++) begin
      lt        = (sum_s[k] < min_s);
      min_idx_s = lt ? AW'(k) : min_idx_s;
      min_s     = lt ? sum_s[k] : min_s;
    end
  end

  // Pack the metrics, optionally normalised to the minimum.
  always_comb begin
    bm_s = '0;
    for (int k = 0; k < NB; k++) begin
      if (NORM != 0) begin
        bm_s[k*MW +: MW] = sum_s[k] - min_s;
      end else begin
        bm_s[k*MW +: MW] = sum_s[k];
      end
    end
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      bm_r        <= '0;
      min_idx_r   <= '0;
    end else begin
      if (adv2_s) begin
        out_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          bm_r      <= bm_s;
          min_idx_r <= min_idx_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmu_param.sv
// tb_bmu_param: self-checking bench for bmu_param (N=3, Q=3, NB=8).
// Two instances (NORM=0 and NORM=1) receive identical stimulus. A behavioural
// model computes metrics from the rules with integer arithmetic; a queue of
// expected results tracks in-flight symbols and predicts handshake outputs.
module tb_bmu_param;
  import bmu_pkg::*;

  localparam int N    = 3;
  localparam int Q    = 3;
  localparam int NB   = 8;
  localparam int AW   = $clog2(NB);
  localparam int MW   = mw_f(N, Q);
  localparam int RXW  = N * Q;
  localparam int SMAX = 7;

  typedef struct packed {
    logic [NB*MW-1:0] bm_raw;
    logic [NB*MW-1:0] bm_norm;
    logic [AW-1:0]    idx;
    int               cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bmu_param_if #(.N(N), .Q(Q), .NB(NB)) bus0 ();
  bmu_param_if #(.N(N), .Q(Q), .NB(NB)) bus1 ();

  bmu_param #(.N(N), .Q(Q), .NB(NB), .NORM(0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  bmu_param #(.N(N), .Q(Q), .NB(NB), .NORM(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  exp_t             q[$];
  logic [N-1:0]     tbl [NB];
  logic             exp_cfg;
  int               cyc;
  int               errors;
  int               checks;
  int               n_drained;
  int               low_seen;
  logic [NB*MW-1:0] last_bm0;
  logic [NB*MW-1:0] last_bm1;
  logic [AW-1:0]    last_idx0;
  logic [AW-1:0]    last_idx1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fld(input logic [NB*MW-1:0] v, input int k);
    return 64'(v[k*MW +: MW]);
  endfunction

  // Metrics straight from the rules: soft costs r / 7-r, hard costs are
  // Hamming distance of the sample MSB, erased bits cost nothing.
  function automatic exp_t model(input logic [RXW-1:0] r, input logic [N-1:0] e, input logic s);
    int   m [NB];
    int   mn;
    int   mi;
    int   v;
    exp_t x;
    x = '0;
    for (int k = 0; k < NB; k++) begin
      m[k] = 0;
      for (int b = 0; b < N; b++) begin
        v = int'(r[b*Q +: Q]);
        if (!e[b]) begin
          if (s) m[k] += tbl[k][b] ? (SMAX - v) : v;
          else   m[k] += ((v >= 4) != tbl[k][b]) ? 1 : 0;
        end
      end
    end
    mn = m[0];
    mi = 0;
    for (int k = 1; k < NB; k++) begin
      if (m[k] < mn) begin
        mn = m[k];
        mi = k;
      end
    end
    for (int k = 0; k < NB; k++) begin
      x.bm_raw[k*MW +: MW]  = MW'(m[k]);
      x.bm_norm[k*MW +: MW] = MW'(m[k] - mn);
    end
    x.idx = AW'(mi);
    x.cyc = cyc;
    return x;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic v, input logic [RXW-1:0] r, input logic [N-1:0] e,
                      input logic s, input logic ordy, input logic we,
                      input logic [AW-1:0] a, input logic [N-1:0] d, output logic acc);
    logic exp_ir;
    logic exp_ov;
    logic idle;
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.rx = r;        bus1.rx = r;
    bus0.erase = e;     bus1.erase = e;
    bus0.soft_mode = s; bus1.soft_mode = s;
    bus0.out_ready = ordy; bus1.out_ready = ordy;
    bus0.cw_we = we;    bus1.cw_we = we;
    bus0.cw_addr = a;   bus1.cw_addr = a;
    bus0.cw_data = d;   bus1.cw_data = d;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
    if (!exp_ir) low_seen++;
    check("in_ready0", 64'(bus0.in_ready), 64'(exp_ir));
    check("in_ready1", 64'(bus1.in_ready), 64'(exp_ir));
    check("out_valid0", 64'(bus0.out_valid), 64'(exp_ov));
    check("out_valid1", 64'(bus1.out_valid), 64'(exp_ov));
    check("cfg_err0", 64'(bus0.cfg_err), 64'(exp_cfg));
    if (exp_ov) begin
      check("bm_raw", 64'(bus0.bm), 64'(q[0].bm_raw));
      check("bm_norm", 64'(bus1.bm), 64'(q[0].bm_norm));
      check("min_idx0", 64'(bus0.bm_min_idx), 64'(q[0].idx));
      check("min_idx1", 64'(bus1.bm_min_idx), 64'(q[0].idx));
    end
    idle = (q.size() == 0);
    acc  = v && exp_ir;
    if (exp_ov && ordy) begin
      last_bm0  = bus0.bm;
      last_bm1  = bus1.bm;
      last_idx0 = bus0.bm_min_idx;
      last_idx1 = bus1.bm_min_idx;
      n_drained++;
      void'(q.pop_front());
    end
    if (we) begin
      if (idle) tbl[a] = d;
      else      exp_cfg = 1'b1;
    end
    if (acc) q.push_back(model(r, e, s));
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic send_drain(input logic [RXW-1:0] r, input logic [N-1:0] e, input logic s);
    logic acc;
    step(1'b1, r, e, s, 1'b1, 1'b0, '0, '0, acc);
    check("send_accept", 64'(acc), 64'(1));
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, acc);
  endtask

  initial begin
    logic             acc;
    logic [RXW-1:0]   syms [5];
    int               sent;
    int               d0;
    int               l0;
    errors = 0; checks = 0; cyc = 0; n_drained = 0; low_seen = 0;
    exp_cfg = 1'b0;
    for (int k = 0; k < NB; k++) tbl[k] = '0;
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    bus0.rx = '0; bus1.rx = '0; bus0.erase = '0; bus1.erase = '0;
    bus0.soft_mode = 1'b0; bus1.soft_mode = 1'b0;
    bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
    bus0.cw_we = 1'b0; bus1.cw_we = 1'b0;
    bus0.cw_addr = '0; bus1.cw_addr = '0; bus0.cw_data = '0; bus1.cw_data = '0;

    // Reset state.
    @(negedge clock);
    check("rst_out_valid", 64'(bus0.out_valid), 64'(0));
    check("rst_bm", 64'(bus0.bm), 64'(0));
    check("rst_idx", 64'(bus0.bm_min_idx), 64'(0));
    check("rst_cfg_err", 64'(bus1.cfg_err), 64'(0));
    reset_n = 1'b1;

    // Load the legacy identity table while idle.
    for (int k = 0; k < NB; k++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, AW'(k), DEF_CW[k], acc);

    // Hard decision, rx = {7,0,0}.
    send_drain({3'd7, 3'd0, 3'd0}, 3'b000, 1'b0);
    check("hard_bm4", fld(last_bm0, 4), 64'(0));
    check("hard_bm0", fld(last_bm0, 0), 64'(1));
    check("hard_bm3", fld(last_bm0, 3), 64'(3));
    check("hard_bm7", fld(last_bm0, 7), 64'(2));
    check("hard_idx", 64'(last_idx0), 64'(4));

    // Soft decision, rx = {7,0,0} then {4,3,0}.
    send_drain({3'd7, 3'd0, 3'd0}, 3'b000, 1'b1);
    check("soft_bm0", fld(last_bm0, 0), 64'(7));
    check("soft_bm4", fld(last_bm0, 4), 64'(0));
    check("soft_bm7", fld(last_bm0, 7), 64'(14));
    send_drain({3'd4, 3'd3, 3'd0}, 3'b000, 1'b1);
    check("soft2_bm0", fld(last_bm0, 0), 64'(7));
    check("soft2_bm4", fld(last_bm0, 4), 64'(6));
    check("soft2_bm6", fld(last_bm0, 6), 64'(7));
    check("soft2_idx", 64'(last_idx0), 64'(4));

    // Erasure of the codeword MSB.
    send_drain({3'd7, 3'd0, 3'd0}, 3'b100, 1'b1);
    check("era_bm0", fld(last_bm0, 0), 64'(0));
    check("era_bm4", fld(last_bm0, 4), 64'(0));
    check("era_bm3", fld(last_bm0, 3), 64'(14));
    check("era_idx", 64'(last_idx0), 64'(0));

    // Normalised output, soft rx = {4,4,4}: raw metric is 12 - popcount(k).
    send_drain({3'd4, 3'd4, 3'd4}, 3'b000, 1'b1);
    check("norm_bm0", fld(last_bm1, 0), 64'(3));
    check("norm_bm7", fld(last_bm1, 7), 64'(0));
    check("norm_bm5", fld(last_bm1, 5), 64'(1));
    check("norm_idx", 64'(last_idx1), 64'(7));

    // Backpressure: five symbols, consumer stalled in cycles 3..6.
    for (int i = 0; i < 5; i++) syms[i] = RXW'($urandom);
    sent = 0; d0 = n_drained; l0 = low_seen;
    for (int c = 0; c < 40 && !(sent == 5 && q.size() == 0); c++) begin
      step(sent < 5, syms[(sent < 5) ? sent : 0], 3'b000, 1'b1,
           !(c >= 3 && c <= 6), 1'b0, '0, '0, acc);
      if (acc) sent++;
    end
    check("bp_sent", 64'(sent), 64'(5));
    check("bp_drained", 64'(n_drained - d0), 64'(5));
    check("bp_stall_seen", 64'(low_seen > l0), 64'(1));

    // Write attempt while busy is ignored and flagged.
    step(1'b1, {3'd7, 3'd0, 3'd7}, 3'b000, 1'b0, 1'b0, 1'b0, '0, '0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 3'd2, 3'b101, acc);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, acc);
    check("cfg_err_set", 64'(bus0.cfg_err), 64'(1));
    send_drain({3'd7, 3'd0, 3'd7}, 3'b000, 1'b0);
    check("tbl_kept_bm2", fld(last_bm0, 2), 64'(3));

    // Idle write and symbol in the same cycle: symbol sees the new entry.
    step(1'b1, {3'd7, 3'd0, 3'd7}, 3'b000, 1'b0, 1'b1, 1'b1, 3'd2, 3'b101, acc);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, acc);
    check("cfg_bm2", fld(last_bm0, 2), 64'(0));
    check("cfg_sticky", 64'(bus1.cfg_err), 64'(1));

    // Random streaming with random stalls, erasures, modes and writes.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, RXW'($urandom),
           ($urandom_range(0, 3) == 0) ? N'($urandom) : 3'b000,
           1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, AW'($urandom), N'($urandom), acc);
    end

    // Reset with both stages full.
    step(1'b1, RXW'($urandom), 3'b000, 1'b1, 1'b0, 1'b0, '0, '0, acc);
    step(1'b1, RXW'($urandom), 3'b000, 1'b1, 1'b0, 1'b0, '0, '0, acc);
    check("full_before_rst", 64'(q.size()), 64'(2));
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid0", 64'(bus0.out_valid), 64'(0));
    check("arst_out_valid1", 64'(bus1.out_valid), 64'(0));
    check("arst_bm0", 64'(bus0.bm), 64'(0));
    check("arst_bm1", 64'(bus1.bm), 64'(0));
    check("arst_cfg_err", 64'(bus0.cfg_err), 64'(0));
    q.delete();
    for (int k = 0; k < NB; k++) tbl[k] = '0;
    exp_cfg = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, {3'd5, 3'd2, 3'd6}, 3'b000, 1'b1, 1'b1, 1'b0, '0, '0, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, acc);
    check("post_rst_lat1", 64'(bus0.out_valid), 64'(1));
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, '0, acc);
    check("post_rst_drained", 64'(q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
